anapad_tap_seq: RTL and testbench



---
 rtl/anapad_pkg.sv | 27 ++
 rtl/anapad_dwell_cnt.sv | 34 +++
 rtl/anapad_tap_seq.sv | 182 ++++++++++++++++++
 tb/tb_anapad_tap_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/anapad_pkg.sv
// Shared state encoding, timing defaults and index helpers for the resistive-tap sequencer.
package anapad_pkg;

  localparam int MAX_TAPS          = 8;
  localparam int DEF_NUM_TAPS      = 4;
  localparam int DEF_BBM_CYCLES    = 8;
  localparam int DEF_SETTLE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ON,
    ST_BREAK,
    ST_SETTLE
  } state_e;

  function automatic int tap_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_TAPS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_TAPS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/anapad_dwell_cnt.sv
// Loadable down-counter shared by the break and settle dwells; expire is high for the one
// cycle the count sits at 1, so the owner acts on the edge where the count reaches zero.
module anapad_dwell_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/anapad_tap_seq.sv
// Break-before-make sequencer for the pad's resistive-tap switches: a captured request is acted
// on one edge after acceptance, and every switch stays open for the break dwell before any closes.
module anapad_tap_seq
  import anapad_pkg::*;
#(
  parameter int NUM_TAPS      = DEF_NUM_TAPS,
  parameter int BBM_CYCLES    = DEF_BBM_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_OFF,
  input  logic [$clog2(NUM_TAPS)-1:0] REQ_TAP,
  output logic [NUM_TAPS-1:0]         SW_EN,
  output logic [$clog2(NUM_TAPS)-1:0] ACTIVE_TAP,
  output logic                        CONNECTED,
  output logic                        DONE,
  output logic                        ERR
);

  localparam int TW   = tap_w(NUM_TAPS);
  localparam int DMAX = (BBM_CYCLES > SETTLE_CYCLES) ? BBM_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(DMAX + 1);

  state_e              state_q, state_d;
  logic [NUM_TAPS-1:0] sw_en_q, sw_en_d;
  logic [TW-1:0]       active_tap_q, active_tap_d;
  logic [TW-1:0]       req_tap_q, req_tap_d;
  logic                req_off_q, req_off_d;
  logic                pend_q, pend_d;
  logic                rdy_q, rdy_d;
  logic                connected_q, connected_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                in_switch;
  logic                dwell_load;
  logic [CW-1:0]       dwell_val;
  logic                dwell_expire;

  function automatic logic tap_oob(input logic [TW-1:0] t);
    return int'(t) >= NUM_TAPS;
  endfunction

  assign accept = REQ_VALID & rdy_q;

  // Requests that will open the switches hold READY low from the acceptance edge onward.
  always_comb begin
    in_switch = 1'b0;
    if (REQ_OFF) begin
      in_switch = (state_q == ST_ON);
    end else if (!tap_oob(REQ_TAP)) begin
      in_switch = !((state_q == ST_ON) && (REQ_TAP == active_tap_q));
    end
  end

  always_comb begin
    state_d      = state_q;
    sw_en_d      = sw_en_q;
    active_tap_d = active_tap_q;
    req_tap_d    = req_tap_q;
    req_off_d    = req_off_q;
    pend_d       = 1'b0;
    rdy_d        = rdy_q;
    connected_d  = connected_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    dwell_load   = 1'b0;
    dwell_val    = '0;

    case (state_q)
      ST_OFF, ST_ON: begin
        if (pend_q) begin
          if (req_off_q) begin
            if (state_q == ST_ON) begin
              sw_en_d     = '0;
              connected_d = 1'b0;
              state_d     = ST_BREAK;
              dwell_load  = 1'b1;
              dwell_val   = CW'(BBM_CYCLES);
            end else begin
              done_d = 1'b1;
            end
          end else if (tap_oob(req_tap_q)) begin
            err_d = 1'b1;
          end else if ((state_q == ST_ON) && (req_tap_q == active_tap_q)) begin
            done_d = 1'b1;
          end else begin
            sw_en_d     = '0;
            connected_d = 1'b0;
            state_d     = ST_BREAK;
            dwell_load  = 1'b1;
            dwell_val   = CW'(BBM_CYCLES);
          end
        end
      end
      ST_BREAK: begin
        if (dwell_expire) begin
          if (req_off_q) begin
            state_d = ST_OFF;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
          end else begin
            sw_en_d      = NUM_TAPS'(onehot(3'(req_tap_q)));
            active_tap_d = req_tap_q;
            state_d      = ST_SETTLE;
            dwell_load   = 1'b1;
            dwell_val    = CW'(SETTLE_CYCLES);
          end
        end
      end
      ST_SETTLE: begin
        if (dwell_expire) begin
          state_d     = ST_ON;
          connected_d = 1'b1;
          done_d      = 1'b1;
          rdy_d       = 1'b1;
        end
      end
      default: begin
        state_d     = ST_OFF;
        sw_en_d     = '0;
        connected_d = 1'b0;
        rdy_d       = 1'b1;
      end
    endcase

    if (accept) begin
      req_off_d = REQ_OFF;
      req_tap_d = REQ_TAP;
      pend_d    = 1'b1;
      rdy_d     = !in_switch;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_OFF;
      sw_en_q      <= '0;
      active_tap_q <= '0;
      req_tap_q    <= '0;
      req_off_q    <= 1'b0;
      pend_q       <= 1'b0;
      rdy_q        <= 1'b1;
      connected_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sw_en_q      <= sw_en_d;
      active_tap_q <= active_tap_d;
      req_tap_q    <= req_tap_d;
      req_off_q    <= req_off_d;
      pend_q       <= pend_d;
      rdy_q        <= rdy_d;
      connected_q  <= connected_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  anapad_dwell_cnt #(
    .W (CW)
  ) u_dwell (
    .clk    (CLK),
    .rst    (RST),
    .load   (dwell_load),
    .value  (dwell_val),
    .expire (dwell_expire)
  );

  assign REQ_READY  = rdy_q;
  assign SW_EN      = sw_en_q;
  assign ACTIVE_TAP = active_tap_q;
  assign CONNECTED  = connected_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_anapad_tap_seq.sv
// Directed bench for the tap sequencer: default 4-tap instance plus a 3-tap instance for out-of-range taps.
module tb_anapad_tap_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_off, req_ready;
  logic [1:0] req_tap, active_tap;
  logic [3:0] sw_en;
  logic       connected, done, err;

  logic       req_valid3, req_off3, req_ready3;
  logic [1:0] req_tap3, active_tap3;
  logic [2:0] sw_en3;
  logic       connected3, done3, err3;

  int checks = 0;
  int errors = 0;

  anapad_tap_seq #(.NUM_TAPS(4), .BBM_CYCLES(8), .SETTLE_CYCLES(16)) u_dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_OFF(req_off), .REQ_TAP(req_tap), .SW_EN(sw_en), .ACTIVE_TAP(active_tap),
    .CONNECTED(connected), .DONE(done), .ERR(err)
  );

  anapad_tap_seq #(.NUM_TAPS(3), .BBM_CYCLES(2), .SETTLE_CYCLES(3)) u_dut3 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
    .REQ_OFF(req_off3), .REQ_TAP(req_tap3), .SW_EN(sw_en3), .ACTIVE_TAP(active_tap3),
    .CONNECTED(connected3), .DONE(done3), .ERR(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge on the 4-tap instance, checking the switch-safety invariants across it.
  task automatic step();
    logic [3:0] prev;
    prev = sw_en;
    tick();
    chk("sw_onehot0", 32'($onehot0(sw_en)), 1);
    chk("sw_no_direct_swap", 32'((prev == 4'b0) || (sw_en == 4'b0) || (sw_en == prev)), 1);
  endtask

  // Switching request on the 4-tap instance; conflicting request held during the sequence.
  task automatic do_switch(input logic [1:0] tap);
    logic [3:0] oh;
    oh        = 4'b0001 << tap;
    req_valid = 1'b1;
    req_off   = 1'b0;
    req_tap   = tap;
    step();
    req_tap   = tap + 2'd1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("sw_seq", sw_en, (k >= 9) ? oh : 4'b0000);
      chk("done_seq", done, k == 25);
      chk("conn_seq", connected, k == 25);
      chk("rdy_seq", req_ready, k == 25);
    end
    req_valid = 1'b0;
    chk("active_after_switch", active_tap, tap);
    chk("err_after_switch", err, 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_off    = 1'b0;
    req_tap    = 2'd0;
    req_valid3 = 1'b0;
    req_off3   = 1'b0;
    req_tap3   = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_sw", sw_en, 0);
    chk("rst_conn", connected, 0);
    chk("rst_rdy", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_active", active_tap, 0);
    chk("rst3_sw", sw_en3, 0);
    chk("rst3_rdy", req_ready3, 1);

    do_switch(2'd2);
    do_switch(2'd0);
    do_switch(2'd1);

    // Same tap while connected: null request, one-cycle DONE.
    req_valid = 1'b1;
    req_off   = 1'b0;
    req_tap   = 2'd1;
    step();
    req_valid = 1'b0;
    chk("same_rdy_e0", req_ready, 1);
    chk("same_done_e0", done, 0);
    step();
    chk("same_done_e1", done, 1);
    chk("same_sw_e1", sw_en, 4'b0010);
    chk("same_conn_e1", connected, 1);
    chk("same_rdy_e1", req_ready, 1);
    step();
    chk("same_done_e2", done, 0);

    // Off from ON: break dwell then DONE.
    req_valid = 1'b1;
    req_off   = 1'b1;
    step();
    req_valid = 1'b0;
    req_off   = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("off_sw", sw_en, 0);
      chk("off_conn", connected, 0);
      chk("off_done", done, k == 9);
      chk("off_rdy", req_ready, k == 9);
    end

    // Off while already off: immediate DONE, accepted back-to-back.
    req_valid = 1'b1;
    req_off   = 1'b1;
    step();
    req_valid = 1'b0;
    req_off   = 1'b0;
    chk("off2_done_e0", done, 0);
    chk("off2_rdy_e0", req_ready, 1);
    step();
    chk("off2_done_e1", done, 1);
    chk("off2_sw_e1", sw_en, 0);
    chk("off2_rdy_e1", req_ready, 1);
    step();
    chk("off2_done_e2", done, 0);

    // Reset at edge 12 of a switch to tap 3.
    req_valid = 1'b1;
    req_tap   = 2'd3;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 11; k++) step();
    chk("pre_rst_sw", sw_en, 4'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sw", sw_en, 0);
    chk("mid_rst_rdy", req_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_conn", connected, 0);
    chk("mid_rst_active", active_tap, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("post_rst_idle_done", done, 0);
    end
    do_switch(2'd3);

    // 3-tap instance: connect tap 1, then reject tap 3, then switch to tap 2.
    req_valid3 = 1'b1;
    req_tap3   = 2'd1;
    tick();
    req_valid3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t3_sw_seq", sw_en3, (k >= 3) ? 3'b010 : 3'b000);
      chk("t3_done_seq", done3, k == 6);
    end
    chk("t3_conn", connected3, 1);
    chk("t3_active", active_tap3, 1);

    req_valid3 = 1'b1;
    req_tap3   = 2'd3;
    tick();
    req_valid3 = 1'b0;
    chk("oob_rdy_e0", req_ready3, 1);
    tick();
    chk("oob_err_e1", err3, 1);
    chk("oob_done_e1", done3, 0);
    chk("oob_sw_e1", sw_en3, 3'b010);
    chk("oob_conn_e1", connected3, 1);
    chk("oob_rdy_e1", req_ready3, 1);
    tick();
    chk("oob_err_e2", err3, 0);
    chk("oob_done_e2", done3, 0);

    req_valid3 = 1'b1;
    req_tap3   = 2'd2;
    tick();
    req_valid3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t3b_sw_seq", sw_en3, (k >= 3) ? 3'b100 : 3'b000);
      chk("t3b_done_seq", done3, k == 6);
    end
    chk("t3b_active", active_tap3, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
